// File: rtl/omem_pkg.sv
// Shared opcodes, widths and FSM state type for the output-memory controller.
// Optional spike counting is enabled by defining OMEM_SPIKE_COUNT_EN.
package omem_pkg;

    localparam int unsigned OPC_W     = 4;
    localparam int unsigned DATA_W    = 25;
    localparam int unsigned SPE_W     = 3;
    localparam int unsigned TS_W      = 2;
    localparam int unsigned SPK_A_W   = 10;
    localparam int unsigned SPK_CNT_W = 10;

    localparam logic [OPC_W-1:0] OP_PREVIOUS_POTENTIAL  = 4'd2;
    localparam logic [OPC_W-1:0] OP_FIRST_TIMESTEP_DONE = 4'd15;
    localparam int unsigned      OMEM_ID                = 12;
    localparam int unsigned      SUM_WIDTH              = 13;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        RD_MEM = 3'd2,
        RESP   = 3'd3,
        TSDONE = 3'd4
    } omem_state_t;

endpackage

// File: rtl/omem_ptr_bank.sv
// Per-SPE circular pointers into each SPE's region; one bank for writes, one for reads.
module omem_ptr_bank
    import omem_pkg::*;
#(
    parameter  int unsigned NUM_SPE = 5,
    parameter  int unsigned DEPTH   = 89,
    localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic [SPE_W-1:0] i_sel,
    output logic [PTR_W-1:0] o_ptr_c
);

    logic [PTR_W-1:0] r_ptr [NUM_SPE];
    logic             w_sel_ok;

    assign w_sel_ok = (i_sel < SPE_W'(NUM_SPE));
    assign o_ptr_c  = w_sel_ok ? r_ptr[i_sel] : '0;

    // Wrap back to the start of the region after the last neuron
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPE; i++) begin
                r_ptr[i] <= '0;
            end
        end else if (i_inc && w_sel_ok) begin
            r_ptr[i_sel] <= (r_ptr[i_sel] == PTR_W'(DEPTH - 1)) ? '0
                                                                 : r_ptr[i_sel] + PTR_W'(1);
        end
    end

endmodule

// File: rtl/omem_controller.sv
// Output memory: stores per-neuron residual potentials and spikes from the sum PEs.
// Define OMEM_SPIKE_COUNT_EN to add the spike_count output.
module omem_controller
    import omem_pkg::*;
#(
    parameter int unsigned NUM_SPE      = 5,
    parameter int unsigned REGION_DEPTH = 89,
    parameter int unsigned POT_WIDTH    = SUM_WIDTH,
    parameter int unsigned MAX_TS       = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [OPC_W-1:0]   req_opcode,
    input  logic [DATA_W-1:0]  req_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [OPC_W-1:0]   rsp_dest,
    output logic [OPC_W-1:0]   rsp_opcode,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               ts_done,
    output logic [TS_W-1:0]    ts_cur,
    input  logic [SPK_A_W-1:0] spk_addr,
    input  logic               spk_ts,
    output logic               spk_data,
    output logic               err_sticky
`ifdef OMEM_SPIKE_COUNT_EN
    ,
    output logic [SPK_CNT_W-1:0] spike_count
`endif
);

    localparam int unsigned TOTAL = NUM_SPE * REGION_DEPTH;
    localparam int unsigned IDX_W = $clog2(TOTAL);
    localparam int unsigned PTR_W = $clog2(REGION_DEPTH);
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned TSI_W = (MAX_TS > 1) ? $clog2(MAX_TS) : 1;

    omem_state_t           r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_data;
    logic [SPE_W-1:0]      r_spe;
    logic [POT_WIDTH-1:0]  r_pot_q;
    logic                  r_spk_q;
    logic                  r_rd_stage;
    logic                  r_vld_q;
    logic [TOTAL-1:0]      r_vld;
    logic [CNT_W-1:0]      r_wcnt;
    logic                  r_ts_done;
    logic [TS_W-1:0]       r_ts_cur;
    logic                  r_err;
    logic [POT_WIDTH-1:0]  r_mem_q;
    logic [POT_WIDTH-1:0]  r_pot [TOTAL];
    logic [TOTAL-1:0]      r_spk [MAX_TS];
`ifdef OMEM_SPIKE_COUNT_EN
    logic [SPK_CNT_W-1:0]  r_spike_count;
`endif

    logic [SPE_W-1:0]      w_req_spe;
    logic                  w_req_rd;
    logic                  w_req_legal;
    logic [POT_WIDTH-1:0]  w_req_pot;
    logic                  w_unused_data;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [PTR_W-1:0]      w_wptr;
    logic [PTR_W-1:0]      w_rptr;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [TSI_W-1:0]      w_ts_idx;

    assign w_req_spe     = req_opcode[OPC_W-1:1];
    assign w_req_rd      = req_opcode[0];
    assign w_req_legal   = (w_req_spe < SPE_W'(NUM_SPE));
    // Potential bits above POT_WIDTH are dropped, not saturated
    assign w_req_pot     = req_data[POT_WIDTH:1];
    assign w_unused_data = ^req_data[DATA_W-1:POT_WIDTH+1];

    assign w_wr_en  = (r_state == WRITE);
    assign w_rd_en  = (r_state == RD_MEM) && !r_rd_stage;
    assign w_wr_idx = IDX_W'(r_spe) * IDX_W'(REGION_DEPTH) + IDX_W'(w_wptr);
    assign w_rd_idx = IDX_W'(r_spe) * IDX_W'(REGION_DEPTH) + IDX_W'(w_rptr);
    assign w_ts_idx = TSI_W'(r_ts_cur - TS_W'(1));

    omem_ptr_bank #(
        .NUM_SPE (NUM_SPE),
        .DEPTH   (REGION_DEPTH)
    ) u_wptr (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_wr_en),
        .i_sel   (r_spe),
        .o_ptr_c (w_wptr)
    );

    omem_ptr_bank #(
        .NUM_SPE (NUM_SPE),
        .DEPTH   (REGION_DEPTH)
    ) u_rptr (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_rd_en),
        .i_sel   (r_spe),
        .o_ptr_c (w_rptr)
    );

    // Storage arrays carry no reset; stale contents are hidden by r_vld
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_pot[w_wr_idx]           <= r_pot_q;
            r_spk[w_ts_idx][w_wr_idx] <= r_spk_q;
        end
        if (w_rd_en) begin
            r_mem_q <= r_pot[w_rd_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_spe         <= '0;
            r_pot_q       <= '0;
            r_spk_q       <= 1'b0;
            r_rd_stage    <= 1'b0;
            r_vld_q       <= 1'b0;
            r_vld         <= '0;
            r_wcnt        <= '0;
            r_ts_done     <= 1'b0;
            r_ts_cur      <= TS_W'(1);
            r_err         <= 1'b0;
`ifdef OMEM_SPIKE_COUNT_EN
            r_spike_count <= '0;
`endif
        end else begin
            r_ts_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        // Illegal SPE ids are swallowed: only the sticky flag changes
                        if (!w_req_legal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_spe       <= w_req_spe;
                            r_pot_q     <= w_req_pot;
                            r_spk_q     <= req_data[0];
                            r_req_ready <= 1'b0;
                            r_state     <= w_req_rd ? RD_MEM : WRITE;
                        end
                    end
                end
                WRITE: begin
                    r_vld[w_wr_idx] <= 1'b1;
                    r_wcnt          <= r_wcnt + CNT_W'(1);
`ifdef OMEM_SPIKE_COUNT_EN
                    if (r_spk_q) begin
                        r_spike_count <= r_spike_count + SPK_CNT_W'(1);
                    end
`endif
                    if (r_wcnt == CNT_W'(TOTAL - 1)) begin
                        r_ts_done <= 1'b1;
                        r_state   <= TSDONE;
                    end else begin
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                RD_MEM: begin
                    // Two cycles: array read, then masking into the response register
                    if (!r_rd_stage) begin
                        r_rd_stage <= 1'b1;
                        r_vld_q    <= r_vld[w_rd_idx];
                    end else begin
                        r_rd_stage  <= 1'b0;
                        r_rsp_data  <= r_vld_q ? DATA_W'(r_mem_q) : '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                TSDONE: begin
                    r_wcnt <= '0;
                    if (r_ts_cur < TS_W'(MAX_TS)) begin
                        r_ts_cur <= r_ts_cur + TS_W'(1);
                    end
`ifdef OMEM_SPIKE_COUNT_EN
                    r_spike_count <= '0;
`endif
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_dest   = OPC_W'(r_spe);
    assign rsp_opcode = OP_PREVIOUS_POTENTIAL;
    assign ts_done    = r_ts_done;
    assign ts_cur     = r_ts_cur;
    assign err_sticky = r_err;
    assign spk_data   = (spk_addr < SPK_A_W'(TOTAL)) ? r_spk[TSI_W'(spk_ts)][IDX_W'(spk_addr)]
                                                     : 1'b0;
`ifdef OMEM_SPIKE_COUNT_EN
    assign spike_count = r_spike_count;
`endif

endmodule

// File: tb/tb_omem_controller.sv
// Directed-plus-random bench for omem_controller against an array-based reference model.
`timescale 1ns/1ps
module tb_omem_controller;

    localparam int NSPE  = 5;
    localparam int DEPTH = 89;
    localparam int TOTAL = NSPE * DEPTH;
    localparam int MAXTS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_opcode;
    logic [24:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_dest;
    logic [3:0]  rsp_opcode;
    logic [24:0] rsp_data;
    logic        ts_done;
    logic [1:0]  ts_cur;
    logic [9:0]  spk_addr;
    logic        spk_ts;
    logic        spk_data;
    logic        err_sticky;
`ifdef OMEM_SPIKE_COUNT_EN
    logic [9:0]  spike_count;
`endif

    omem_controller dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_dest   (rsp_dest),
        .rsp_opcode (rsp_opcode),
        .rsp_data   (rsp_data),
        .ts_done    (ts_done),
        .ts_cur     (ts_cur),
        .spk_addr   (spk_addr),
        .spk_ts     (spk_ts),
        .spk_data   (spk_data),
`ifdef OMEM_SPIKE_COUNT_EN
        .spike_count(spike_count),
`endif
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ts_high_cycles = 0;

    always @(negedge clk) begin
        if (ts_done === 1'b1) ts_high_cycles++;
    end

    // Reference model: one slot per neuron, spikes kept per timestep
    int m_pot [TOTAL];
    bit m_vld [TOTAL];
    bit m_spk [MAXTS][TOTAL];
    bit m_known [MAXTS][TOTAL];
    int m_wptr [NSPE];
    int m_rptr [NSPE];
    int m_wcnt, m_ts, m_scnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TOTAL; i++) m_vld[i] = 1'b0;
        for (int s = 0; s < NSPE; s++) begin
            m_wptr[s] = 0;
            m_rptr[s] = 0;
        end
        m_wcnt = 0;
        m_ts   = 1;
        m_scnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_ts_done", 32'(ts_done), 0);
        chk("rst_ts_cur", 32'(ts_cur), 1);
        chk("rst_err", 32'(err_sticky), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Issue one request, wait for acceptance, and advance the model
    task automatic send(input logic [3:0] opc, input logic [24:0] d,
                        output int exp_pot, output int idx);
        int n;
        int spe;
        exp_pot = 0;
        idx = -1;
        @(negedge clk);
        req_opcode = opc;
        req_data = d;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", 32'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        spe = int'(opc[3:1]);
        if (spe >= NSPE) begin
            // no model change
        end else if (opc[0]) begin
            idx = spe * DEPTH + m_rptr[spe];
            exp_pot = m_vld[idx] ? m_pot[idx] : 0;
            m_rptr[spe] = (m_rptr[spe] + 1) % DEPTH;
        end else begin
            idx = spe * DEPTH + m_wptr[spe];
            m_pot[idx] = int'(d[13:1]);
            m_vld[idx] = 1'b1;
            m_spk[m_ts-1][idx] = d[0];
            m_known[m_ts-1][idx] = 1'b1;
            m_wptr[spe] = (m_wptr[spe] + 1) % DEPTH;
            m_scnt += int'(d[0]);
            m_wcnt++;
            if (m_wcnt == TOTAL) begin
                m_wcnt = 0;
                m_scnt = 0;
                if (m_ts < MAXTS) m_ts++;
            end
        end
    endtask

    task automatic wr(input int spe, input logic [24:0] d);
        int e, idx;
        send({3'(spe), 1'b0}, d, e, idx);
    endtask

    task automatic rd(input int spe, input int stall);
        int e, idx;
        send({3'(spe), 1'b1}, 25'($urandom), e, idx);
        @(posedge clk); #1;
        chk("rsp_early", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_data", 32'(rsp_data), e);
        chk("rsp_dest", 32'(rsp_dest), spe);
        chk("rsp_opcode", 32'(rsp_opcode), 2);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_data", 32'(rsp_data), e);
            chk("bp_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_release", 32'(rsp_valid), 0);
    endtask

    task automatic chk_spk(input int ts, input int idx);
        spk_ts = 1'(ts);
        spk_addr = 10'(idx);
        #1;
        if (m_known[ts][idx]) chk("spk_data", 32'(spk_data), 32'(m_spk[ts][idx]));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int base;
        logic [24:0] d;
        reset = 1'b0;
        req_valid = 1'b0;
        req_opcode = '0;
        req_data = '0;
        rsp_ready = 1'b0;
        spk_addr = '0;
        spk_ts = 1'b0;
        for (int t = 0; t < MAXTS; t++)
            for (int i = 0; i < TOTAL; i++) m_known[t][i] = 1'b0;

        do_reset();

        // Read before any write returns zero
        rd(0, 0);
        chk("err_after_rd", 32'(err_sticky), 0);

        // Write 70 with spike to SPE 2, read it back
        wr(2, {11'd0, 13'd70, 1'b1});
        rd(2, 0);
        repeat (2) @(posedge clk);
        chk_spk(0, 2 * DEPTH);

        // Response backpressure
        wr(3, 25'($urandom));
        rd(3, 5);

        // Random mix with full-width payloads (upper bits must be ignored)
        for (int i = 0; i < 40; i++) begin
            s = int'($urandom_range(0, NSPE - 1));
            if ($urandom_range(0, 1) == 1) rd(s, 0);
            else wr(s, 25'($urandom));
        end
        repeat (2) @(posedge clk);
        for (int i = 0; i < TOTAL; i++) chk_spk(0, i);
        spk_addr = 10'd1000;
        #1;
        chk("spk_oob", 32'(spk_data), 0);

        // Illegal SPE ids: accepted, flagged, nothing else changes
        wr(6, 25'($urandom));
        repeat (2) @(posedge clk); #1;
        chk("err_set", 32'(err_sticky), 1);
        chk("illegal_ready", 32'(req_ready), 1);
        rd_illegal: begin
            int e, idx;
            send({3'd7, 1'b1}, 25'($urandom), e, idx);
            repeat (4) begin
                @(posedge clk); #1;
                chk("illegal_no_rsp", 32'(rsp_valid), 0);
            end
        end
        for (int i = 0; i < NSPE; i++) rd(i, 0);
        for (int i = 0; i < TOTAL; i++) chk_spk(0, i);
`ifdef OMEM_SPIKE_COUNT_EN
        chk("spike_count_mix", 32'(spike_count), m_scnt);
`endif

        // Region wrap: 90 writes from SPE 1, the last lands at index 89
        do_reset();
        d = '0;
        for (int i = 0; i < 90; i++) begin
            d = 25'($urandom);
            wr(1, d);
        end
        repeat (2) @(posedge clk);
        spk_ts = 1'b0;
        spk_addr = 10'd89;
        #1;
        chk("wrap_spk", 32'(spk_data), 32'(d[0]));
`ifdef OMEM_SPIKE_COUNT_EN
        chk("spike_count_wrap", 32'(spike_count), m_scnt);
`endif
        for (int i = 0; i < DEPTH; i++) rd(1, 0);
        rd(1, 0);

        // Timestep completion after 89 writes per SPE
        do_reset();
        base = ts_high_cycles;
        for (int i = 0; i < TOTAL - 1; i++) wr(i % NSPE, 25'($urandom));
        repeat (3) @(posedge clk); #1;
        chk("ts_no_pulse_early", 32'(ts_high_cycles - base), 0);
        chk("ts_cur_before", 32'(ts_cur), 1);
        wr(NSPE - 1, 25'($urandom));
        repeat (4) @(posedge clk); #1;
        chk("ts_pulse_once", 32'(ts_high_cycles - base), 1);
        chk("ts_cur_after", 32'(ts_cur), m_ts);
`ifdef OMEM_SPIKE_COUNT_EN
        chk("spike_count_ts", 32'(spike_count), 0);
`endif
        for (int i = 0; i < 12; i++) chk_spk(0, int'($urandom_range(0, TOTAL - 1)));
        wr(0, 25'($urandom));
        repeat (2) @(posedge clk);
        chk_spk(1, 0);
        chk_spk(0, 0);
        rd(0, 0);

        // Second timestep: ts_cur saturates
        for (int i = 0; i < TOTAL - 1; i++) wr(int'($urandom_range(0, NSPE - 1)), 25'($urandom));
        repeat (4) @(posedge clk); #1;
        chk("ts_pulse_sat", 32'(ts_high_cycles - base), 2);
        chk("ts_cur_sat", 32'(ts_cur), m_ts);

        // Reset while a response is pending
        wr(4, 25'($urandom));
        rd_reset: begin
            int e, idx;
            send({3'd4, 1'b1}, 25'($urandom), e, idx);
            @(posedge clk);
            @(posedge clk); #1;
            chk("pre_rst_valid", 32'(rsp_valid), 1);
            #2;
            reset = 1'b1;
            #1;
            chk("mid_rst_valid", 32'(rsp_valid), 0);
            chk("mid_rst_ready", 32'(req_ready), 0);
            chk("mid_rst_ts_cur", 32'(ts_cur), 1);
            @(negedge clk);
            reset = 1'b0;
            model_reset();
            repeat (3) begin
                @(posedge clk); #1;
                chk("post_rst_no_rsp", 32'(rsp_valid), 0);
            end
        end
        rd(4, 0);
        chk("post_rst_err", 32'(err_sticky), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
